cnn_layer_accel_octo_input_sched: RTL and testbench

- Scheduler that shares one upstream input stream between C_NUM_OCTO octo blocks.
- Watches each octo's pixel and sequencer ready flags, picks one target per burst and requests a burst from upstream.
- Forwards C_BURST_LEN words to the chosen octo with the correct tag and valid.
- Sits between the DMA/input FIFO and the octo array; only the target octo sees valid high.

---
 rtl/cnn_layer_accel_octo_input_sched.sv | 210 +++++++++++++++++++++
 tb/tb_cnn_layer_accel_octo_input_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_octo_input_sched.sv
// Shares one upstream burst stream between C_NUM_OCTO octo blocks using round-robin selection.
// Optional build macro OCTO_INPUT_SCHED_PERF_CNT_EN adds stall and completed-burst counters.
module cnn_layer_accel_octo_input_sched #(
    parameter int C_NUM_OCTO    = 4,
    parameter int C_PIXEL_WIDTH = 18,
    parameter int C_BURST_LEN   = 16,
    localparam int C_LOG2_NUM_OCTO = (C_NUM_OCTO > 1) ? $clog2(C_NUM_OCTO) : 1
) (
    input  logic                       clk_500MHz,
    input  logic                       rst,
    input  logic [C_NUM_OCTO-1:0]      octo_pixel_datain_rdy,
    input  logic [C_NUM_OCTO-1:0]      octo_seq_datain_rdy,
    output logic                       req_valid,
    output logic [C_LOG2_NUM_OCTO-1:0] req_octo,
    output logic                       req_seq,
    input  logic                       req_ack,
    input  logic [C_PIXEL_WIDTH-1:0]   up_datain,
    input  logic                       up_datain_valid,
    output logic                       up_datain_rdy,
    output logic [C_PIXEL_WIDTH-1:0]   octo_datain,
    output logic [C_NUM_OCTO-1:0]      octo_datain_valid,
    output logic [C_NUM_OCTO-1:0]      octo_pixel_datain_tag,
    output logic [C_NUM_OCTO-1:0]      octo_seq_datain_tag,
    output logic                       busy
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                stall_count,
    output logic [31:0]                burst_count
`endif
);

    localparam int CNT_W = $clog2(C_BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_BURST_LEN - 1);

    typedef logic [C_LOG2_NUM_OCTO-1:0] octo_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_REQ   = 3'b010,
        ST_BURST = 3'b100
    } state_t;

    state_t                   state_reg, state_next;
    octo_idx_t                seq_ptr_reg, seq_ptr_next;
    octo_idx_t                pix_ptr_reg, pix_ptr_next;
    octo_idx_t                req_octo_reg, req_octo_next;
    logic                     req_seq_reg, req_seq_next;
    logic [CNT_W-1:0]         burst_cnt_reg, burst_cnt_next;
    logic [C_PIXEL_WIDTH-1:0] data_reg, data_next;
    logic [C_NUM_OCTO-1:0]    valid_reg, valid_next;
    logic [C_NUM_OCTO-1:0]    pix_tag_reg, pix_tag_next;
    logic [C_NUM_OCTO-1:0]    seq_tag_reg, seq_tag_next;
    logic [C_NUM_OCTO-1:0]    target_onehot;
    logic [C_LOG2_NUM_OCTO:0] seq_pick, pix_pick;
    logic                     last_word;

    // Returns {found, index} of the first set bit at or after ptr, wrapping circularly.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [C_LOG2_NUM_OCTO:0] rr_pick(
        input logic [C_NUM_OCTO-1:0] vec,
        input octo_idx_t             ptr
    );
        logic      found;
        octo_idx_t idx;
        int        pos;
        found = 1'b0;
        idx   = '0;
        for (int k = C_NUM_OCTO - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= C_NUM_OCTO) begin
                pos = pos - C_NUM_OCTO;
            end
            if (vec[pos]) begin
                found = 1'b1;
                idx   = octo_idx_t'(pos);
            end
        end
        return {found, idx};
    endfunction

    function automatic octo_idx_t next_idx(input octo_idx_t cur);
        if (int'(cur) == C_NUM_OCTO - 1) begin
            return '0;
        end
        return cur + octo_idx_t'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < C_NUM_OCTO; gi++) begin : g_target
            assign target_onehot[gi] = (req_octo_reg == octo_idx_t'(gi));
        end
    endgenerate

    assign seq_pick  = rr_pick(octo_seq_datain_rdy, seq_ptr_reg);
    assign pix_pick  = rr_pick(octo_pixel_datain_rdy, pix_ptr_reg);
    assign last_word = (burst_cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        seq_ptr_next   = seq_ptr_reg;
        pix_ptr_next   = pix_ptr_reg;
        req_octo_next  = req_octo_reg;
        req_seq_next   = req_seq_reg;
        burst_cnt_next = burst_cnt_reg;
        data_next      = data_reg;
        valid_next     = '0;
        pix_tag_next   = '0;
        seq_tag_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (seq_pick[C_LOG2_NUM_OCTO]) begin
                    req_octo_next = seq_pick[C_LOG2_NUM_OCTO-1:0];
                    req_seq_next  = 1'b1;
                    state_next    = ST_REQ;
                end else if (pix_pick[C_LOG2_NUM_OCTO]) begin
                    req_octo_next = pix_pick[C_LOG2_NUM_OCTO-1:0];
                    req_seq_next  = 1'b0;
                    state_next    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_ack) begin
                    burst_cnt_next = '0;
                    state_next     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (up_datain_valid) begin
                    data_next      = up_datain;
                    valid_next     = target_onehot;
                    burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                    if (req_seq_reg) begin
                        seq_tag_next = target_onehot;
                    end else begin
                        pix_tag_next = target_onehot;
                    end
                    if (last_word) begin
                        state_next = ST_IDLE;
                        if (req_seq_reg) begin
                            seq_ptr_next = next_idx(req_octo_reg);
                        end else begin
                            pix_ptr_next = next_idx(req_octo_reg);
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_500MHz) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            seq_ptr_reg   <= '0;
            pix_ptr_reg   <= '0;
            req_octo_reg  <= '0;
            req_seq_reg   <= 1'b0;
            burst_cnt_reg <= '0;
            data_reg      <= '0;
            valid_reg     <= '0;
            pix_tag_reg   <= '0;
            seq_tag_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            seq_ptr_reg   <= seq_ptr_next;
            pix_ptr_reg   <= pix_ptr_next;
            req_octo_reg  <= req_octo_next;
            req_seq_reg   <= req_seq_next;
            burst_cnt_reg <= burst_cnt_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            pix_tag_reg   <= pix_tag_next;
            seq_tag_reg   <= seq_tag_next;
        end
    end

    assign req_valid             = (state_reg == ST_REQ);
    assign up_datain_rdy         = (state_reg == ST_BURST);
    assign busy                  = (state_reg != ST_IDLE);
    assign req_octo              = req_octo_reg;
    assign req_seq               = req_seq_reg;
    assign octo_datain           = data_reg;
    assign octo_datain_valid     = valid_reg;
    assign octo_pixel_datain_tag = pix_tag_reg;
    assign octo_seq_datain_tag   = seq_tag_reg;

`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
    logic [31:0] stall_count_reg, burst_count_reg;

    always_ff @(posedge clk_500MHz) begin
        if (rst) begin
            stall_count_reg <= '0;
            burst_count_reg <= '0;
        end else begin
            if ((state_reg == ST_BURST) && !up_datain_valid && (stall_count_reg != 32'hFFFF_FFFF)) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
            if ((state_reg == ST_BURST) && up_datain_valid && last_word && (burst_count_reg != 32'hFFFF_FFFF)) begin
                burst_count_reg <= burst_count_reg + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign burst_count = burst_count_reg;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_sched.sv
// Randomised and directed bench for the octo input scheduler, checked every cycle against a
// transaction-level model of the grant/burst rules.
module tb_cnn_layer_accel_octo_input_sched;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  pix_rdy = '0;
    logic [N-1:0]  seq_rdy = '0;
    logic          req_valid;
    logic [1:0]    req_octo;
    logic          req_seq;
    logic          req_ack = 1'b0;
    logic [W-1:0]  up_datain = '0;
    logic          up_datain_valid = 1'b0;
    logic          up_datain_rdy;
    logic [W-1:0]  octo_datain;
    logic [N-1:0]  octo_datain_valid;
    logic [N-1:0]  ptag;
    logic [N-1:0]  stag;
    logic          busy;
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
    logic [31:0]   stall_count;
    logic [31:0]   burst_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    cnn_layer_accel_octo_input_sched #(
        .C_NUM_OCTO(N), .C_PIXEL_WIDTH(W), .C_BURST_LEN(BL)
    ) dut (
        .clk_500MHz(clk),
        .rst(rst),
        .octo_pixel_datain_rdy(pix_rdy),
        .octo_seq_datain_rdy(seq_rdy),
        .req_valid(req_valid),
        .req_octo(req_octo),
        .req_seq(req_seq),
        .req_ack(req_ack),
        .up_datain(up_datain),
        .up_datain_valid(up_datain_valid),
        .up_datain_rdy(up_datain_rdy),
        .octo_datain(octo_datain),
        .octo_datain_valid(octo_datain_valid),
        .octo_pixel_datain_tag(ptag),
        .octo_seq_datain_tag(stag),
        .busy(busy)
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
        ,
        .stall_count(stall_count),
        .burst_count(burst_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = choosing, 1 = waiting for acknowledge, 2 = streaming words.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    int           m_phase = 0, m_target = 0, m_seq = 0, m_left = 0;
    int           m_seq_ptr = 0, m_pix_ptr = 0, m_stall = 0, m_bursts = 0;
    logic [W-1:0] m_data = '0;
    logic [N-1:0] m_valid = '0, m_ptag = '0, m_stag = '0;

    always @(posedge clk) begin
        int p;
        m_valid = '0;
        m_ptag  = '0;
        m_stag  = '0;
        if (rst) begin
            m_phase = 0; m_target = 0; m_seq = 0; m_left = 0;
            m_seq_ptr = 0; m_pix_ptr = 0; m_data = '0; m_stall = 0; m_bursts = 0;
        end else if (m_phase == 0) begin
            p = pick(seq_rdy, m_seq_ptr);
            if (p >= 0) begin
                m_target = p; m_seq = 1; m_phase = 1;
            end else begin
                p = pick(pix_rdy, m_pix_ptr);
                if (p >= 0) begin
                    m_target = p; m_seq = 0; m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (req_ack) begin
                m_phase = 2; m_left = BL;
            end
        end else begin
            if (up_datain_valid) begin
                m_data = up_datain;
                m_valid[m_target] = 1'b1;
                if (m_seq != 0) m_stag[m_target] = 1'b1;
                else            m_ptag[m_target] = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_phase = 0;
                    m_bursts++;
                    if (m_seq != 0) m_seq_ptr = (m_target + 1) % N;
                    else            m_pix_ptr = (m_target + 1) % N;
                end
            end else begin
                m_stall++;
            end
        end
    end

    int got_data[$];
    int got_octo[$];
    int got_seq[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_valid", req_valid, m_phase == 1);
            chk("busy", busy, m_phase != 0);
            chk("up_rdy", up_datain_rdy, m_phase == 2);
            chk("req_octo", req_octo, m_target);
            chk("req_seq", req_seq, m_seq);
            chk("octo_datain", octo_datain, m_data);
            chk("octo_valid", octo_datain_valid, m_valid);
            chk("pix_tag", ptag, m_ptag);
            chk("seq_tag", stag, m_stag);
            chk("onehot_inv", (octo_datain_valid == (ptag | stag)) && ((ptag & stag) == 0)
                && ($countones(octo_datain_valid) <= 1), 1);
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
            chk("stall_count", stall_count, m_stall);
            chk("burst_count", burst_count, m_bursts);
`endif
            for (int i = 0; i < N; i++) begin
                if (octo_datain_valid[i]) begin
                    got_data.push_back(int'(octo_datain));
                    got_octo.push_back(i);
                    got_seq.push_back(int'(stag[i]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_ready();
        seq_rdy = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        pix_rdy = N'($urandom);
        if ((seq_rdy | pix_rdy) == '0) pix_rdy = N'(1 << $urandom_range(0, N - 1));
    endtask

    // Plays the upstream side for one burst: waits for a request, acknowledges, streams BL words.
    task automatic do_burst(input int ack_delay, input int gap_mode, input int word_base,
                            input int drop_after, input logic [N-1:0] drop_pix,
                            input int rst_at, input bit rand_rdy,
                            output int g_octo, output int g_seq, output int waits, output int windows);
        int  n, k;
        bit  v, acc;
        waits = 0; windows = 0; g_octo = -1; g_seq = -1;
        while (!req_valid && waits < 64) begin
            step();
            waits++;
        end
        if (!req_valid) begin
            chk("req_timeout", 0, 1);
            return;
        end
        g_octo = int'(req_octo);
        g_seq  = int'(req_seq);
        repeat (ack_delay) step();
        req_ack = 1'b1;
        step();
        req_ack = 1'b0;
        n = 0; k = 0;
        while (n < BL && windows < 200) begin
            if (rst_at >= 0 && n == rst_at) begin
                rst = 1'b1;
                up_datain_valid = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (k % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            up_datain_valid = v;
            up_datain = W'(word_base + n);
            acc = up_datain_rdy && v;
            if (up_datain_rdy) windows++;
            if (rand_rdy) rand_ready();
            step();
            k++;
            if (acc) begin
                n++;
                if (n == drop_after) pix_rdy = drop_pix;
            end
        end
        up_datain_valid = 1'b0;
        if (n < BL) chk("burst_timeout", n, BL);
    endtask

    int go, gs, gw, gwin;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int rr_got[5];
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
    logic [31:0] stall0, burst0;
`endif

    initial begin
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_up_rdy", up_datain_rdy, 0);
        chk("rst_outputs", {octo_datain, octo_datain_valid, ptag, stag, req_octo, req_seq}, 0);

        // Sequencer priority, ack after 2 cycles, words 0..15
        seq_rdy = 4'b0100; pix_rdy = 4'b1111;
        got_data.delete(); got_octo.delete(); got_seq.delete();
        do_burst(2, 0, 0, -1, '0, -1, 0, go, gs, gw, gwin);
        seq_rdy = 4'b0000;
        settle();
        chk("seq_grant_octo", go, 2);
        chk("seq_grant_seq", gs, 1);
        chk("seq_word_count", got_data.size(), 16);
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            chk("seq_word", {got_data[i], got_octo[i], got_seq[i]}, {32'(i), 32'd2, 32'd1});
        end

        // Pixel round-robin, immediate ack, back-to-back
        for (int b = 0; b < 5; b++) begin
            do_burst(0, 0, 100 * b, -1, '0, -1, 0, go, gs, gw, gwin);
            rr_got[b] = go;
            chk("rr_seq", gs, 0);
            chk("rr_idle_gap", gw, 1);
        end
        for (int b = 0; b < 5; b++) chk("rr_grant", rr_got[b], rr_exp[b]);

        // Upstream gaps: valid 0101..., 32 windows
        settle();
        got_data.delete(); got_octo.delete(); got_seq.delete();
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
        stall0 = stall_count; burst0 = burst_count;
`endif
        do_burst(1, 1, 500, -1, '0, -1, 0, go, gs, gw, gwin);
        pix_rdy = 4'b0010;
        settle();
        chk("gap_grant", go, 1);
        chk("gap_windows", gwin, 32);
        chk("gap_valids", got_data.size(), 16);
`ifdef OCTO_INPUT_SCHED_PERF_CNT_EN
        chk("gap_stall_delta", stall_count - stall0, 16);
        chk("gap_burst_delta", burst_count - burst0, 1);
`endif

        // Ready drop mid-burst on octo 1
        got_data.delete(); got_octo.delete(); got_seq.delete();
        do_burst(0, 0, 700, 5, 4'b1011, -1, 0, go, gs, gw, gwin);
        settle();
        chk("drop_grant", go, 1);
        chk("drop_count", got_data.size(), 16);
        for (int i = 0; i < got_octo.size(); i++) chk("drop_target", got_octo[i], 1);
        do_burst(0, 0, 800, -1, '0, -1, 0, go, gs, gw, gwin);
        chk("drop_skip", go, 3);

        // Move pixel pointer to 2, then reset during a burst to octo 3
        pix_rdy = 4'b0010;
        do_burst(0, 0, 900, -1, '0, -1, 0, go, gs, gw, gwin);
        chk("pre_rst_grant", go, 1);
        pix_rdy = 4'b1000;
        do_burst(0, 0, 1000, -1, '0, 8, 0, go, gs, gw, gwin);
        chk("rst_burst_grant", go, 3);
        chk("midrst_state", {req_valid, busy, up_datain_rdy}, 0);
        chk("midrst_outputs", {octo_datain, octo_datain_valid, ptag, stag, req_octo, req_seq}, 0);
        seq_rdy = 4'b1111; pix_rdy = 4'b1111;
        do_burst(0, 0, 1100, -1, '0, -1, 0, go, gs, gw, gwin);
        chk("post_rst_seq_grant", {go, gs}, {32'd0, 32'd1});
        seq_rdy = 4'b0000;
        do_burst(0, 0, 1200, -1, '0, -1, 0, go, gs, gw, gwin);
        chk("post_rst_pix_grant", {go, gs}, {32'd0, 32'd0});

        // Nothing ready for 100 cycles
        pix_rdy = 4'b0000;
        step();
        for (int i = 0; i < 100; i++) begin
            chk("idle_quiet", {req_valid, busy, up_datain_rdy}, 0);
            step();
        end

        // Randomised bursts
        for (int b = 0; b < 40; b++) begin
            rand_ready();
            do_burst($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 4000),
                     -1, '0, -1, 1, go, gs, gw, gwin);
            $display("burst %0d octo=%0d seq=%0d windows=%0d", b, go, gs, gwin);
        end
        seq_rdy = '0; pix_rdy = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
